// File: rtl/bus_arbiter_if.sv
// Bus arbitration signal bundle: master requests and slave completion in,
// one-hot grant/ack and status out. The arbiter sits on the slave modport.
interface bus_arbiter_if #(
  parameter int N = 4
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  bus_req;
  logic          xfer_done;
  logic [N-1:0]  bus_grant;
  logic [N-1:0]  bus_ack;
  logic [OW-1:0] owner;
  logic          bus_busy;
  logic          timeout_err;

  modport slave (
    input  bus_req, xfer_done,
    output bus_grant, bus_ack, owner, bus_busy, timeout_err
  );

  modport master (
    output bus_req, xfer_done,
    input  bus_grant, bus_ack, owner, bus_busy, timeout_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter. One tenure at a time: IDLE picks a winner starting
// at the priority pointer, GRANT holds the bus until the slave completes or the
// tenure times out, RELEASE drops ack/busy before the next arbitration.
module bus_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  bus_arbiter_if.slave bus
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [OW-1:0] owner_q, owner_d;
  logic          busy_q, busy_d;
  logic          terr_q, terr_d;

  logic [OW-1:0] win;
  logic [OW-1:0] ix;
  logic          tenure_end;

  // Winner scan: walk offsets from far to near so the nearest requester at or
  // after ptr is the last one written.
  always_comb begin
    win = '0;
    ix  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      ix = OW'((int'(ptr_q) + k) % N);
      if (bus.bus_req[ix]) win = ix;
    end
  end

  // Done wins over timeout when both land on the same cycle.
  assign tenure_end = bus.xfer_done || (cnt_q == CW'(TIMEOUT - 1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    ack_d   = ack_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    terr_d  = terr_q;
    case (state_q)
      IDLE: begin
        if (|bus.bus_req) begin
          grant_d = N'(1) << win;
          owner_d = win;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        cnt_d = cnt_q + CW'(1);
        if (tenure_end) begin
          grant_d = '0;
          ack_d   = N'(1) << owner_q;
          terr_d  = !bus.xfer_done;
          ptr_d   = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        ack_d   = '0;
        terr_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any tenure without an ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.bus_grant   = grant_q;
  assign bus.bus_ack     = ack_q;
  assign bus.owner       = owner_q;
  assign bus.bus_busy    = busy_q;
  assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios followed by a randomized run
// checked cycle by cycle against a tenure-level reference model.
// Output vector layout everywhere: {grant[3:0], ack[3:0], owner[1:0], busy, terr}.
module tb_bus_arbiter;
  localparam int N = 4;
  localparam int T = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bus_arbiter_if #(.N(N)) bus ();

  bus_arbiter #(.N(N), .TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic logic [11:0] outs();
    return {bus.bus_grant, bus.bus_ack, bus.owner, bus.bus_busy, bus.timeout_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.bus_req   = '0;
    bus.xfer_done = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] o;
    bus.bus_req   = '0;
    bus.xfer_done = 1'b0;
    #1 reset = 1'b0;
    #2;
    o = outs();
    n_chk++;
    if (o !== 12'b0) begin n_fail++; $display("FAIL reset_async got %b want %b", o, 12'b0); end
    bus.bus_req = 4'b1111;
    tick();
    o = outs();
    n_chk++;
    if (o !== 12'b0) begin n_fail++; $display("FAIL reset_held got %b want %b", o, 12'b0); end
    bus.bus_req = '0;
    reset = 1'b1;
  endtask

  task automatic test_done_idle();
    logic [11:0] o;
    do_reset();
    bus.xfer_done = 1'b1;
    tick();
    tick();
    bus.xfer_done = 1'b0;
    o = outs();
    n_chk++;
    if (o !== 12'b0) begin n_fail++; $display("FAIL done_in_idle got %b want %b", o, 12'b0); end
  endtask

  task automatic test_single();
    logic [11:0] o;
    do_reset();
    bus.bus_req = 4'b0010;
    tick();
    o = outs();
    n_chk++;
    if (o !== {4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL single_grant got %b", o); end
    bus.bus_req = '0;
    tick();
    tick();
    o = outs();
    n_chk++;
    if (o !== {4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL single_hold got %b", o); end
    bus.xfer_done = 1'b1;
    tick();
    bus.xfer_done = 1'b0;
    o = outs();
    n_chk++;
    if (o !== {4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL single_ack got %b", o); end
    tick();
    o = outs();
    n_chk++;
    if (o !== {4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0}) begin n_fail++; $display("FAIL single_release got %b", o); end
  endtask

  task automatic test_contention();
    logic [11:0] o;
    do_reset();
    bus.bus_req = 4'b0101;
    tick();
    o = outs();
    n_chk++;
    if (o !== {4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL contention_first got %b", o); end
    bus.bus_req   = 4'b0100;
    bus.xfer_done = 1'b1;
    tick();
    bus.xfer_done = 1'b0;
    o = outs();
    n_chk++;
    if (o !== {4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL contention_ack got %b", o); end
    tick();
    o = outs();
    n_chk++;
    if (o !== {4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL contention_release got %b", o); end
    tick();
    o = outs();
    n_chk++;
    if (o !== {4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0}) begin n_fail++; $display("FAIL contention_second got %b", o); end
  endtask

  task automatic test_rr_wrap();
    logic [3:0] g;
    logic [3:0] want;
    do_reset();
    bus.bus_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      g    = bus.bus_grant;
      want = 4'(1 << (i % N));
      n_chk++;
      if (g !== want) begin n_fail++; $display("FAIL rr_wrap[%0d] grant got %b want %b", i, g, want); end
      bus.xfer_done = 1'b1;
      tick();
      bus.xfer_done = 1'b0;
      tick();
    end
    bus.bus_req = '0;
  endtask

  task automatic test_timeout();
    logic [11:0] o;
    do_reset();
    bus.bus_req = 4'b0100;
    tick();
    bus.bus_req = '0;
    for (int c = 1; c < T; c++) begin
      tick();
      o = outs();
      n_chk++;
      if (o !== {4'b0100, 4'b0000, 2'd2, 1'b1, 1'b0}) begin n_fail++; $display("FAIL timeout_hold[%0d] got %b", c, o); end
    end
    tick();
    o = outs();
    n_chk++;
    if (o !== {4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1}) begin n_fail++; $display("FAIL timeout_ack got %b", o); end
    tick();
    o = outs();
    n_chk++;
    if (o !== {4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0}) begin n_fail++; $display("FAIL timeout_release got %b", o); end
  endtask

  task automatic test_coincident();
    logic [11:0] o;
    do_reset();
    bus.bus_req = 4'b0001;
    tick();
    bus.bus_req = '0;
    for (int c = 1; c < T; c++) tick();
    bus.xfer_done = 1'b1;
    tick();
    bus.xfer_done = 1'b0;
    o = outs();
    n_chk++;
    if (o !== {4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL coincident_ack got %b", o); end
  endtask

  task automatic test_reset_mid();
    logic [11:0] o;
    do_reset();
    bus.bus_req = 4'b1000;
    tick();
    o = outs();
    n_chk++;
    if (o !== {4'b1000, 4'b0000, 2'd3, 1'b1, 1'b0}) begin n_fail++; $display("FAIL reset_mid_grant got %b", o); end
    bus.bus_req = '0;
    tick();
    #2 reset = 1'b0;
    #1;
    o = outs();
    n_chk++;
    if (o !== 12'b0) begin n_fail++; $display("FAIL reset_mid_async got %b want %b", o, 12'b0); end
    @(negedge clk);
    reset = 1'b1;
    bus.bus_req = 4'b1001;
    tick();
    o = outs();
    n_chk++;
    if (o !== {4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL reset_mid_regrant got %b", o); end
    bus.bus_req = '0;
  endtask

  // Reference model tracks a tenure as (owner, cycles elapsed) plus a flag for
  // the single release cycle that follows its ack.
  task automatic test_random();
    logic [3:0]  req;
    logic        done;
    logic [11:0] o;
    logic [11:0] e;
    logic [3:0]  e_grant = '0;
    logic [3:0]  e_ack   = '0;
    logic        e_busy  = 1'b0;
    logic        e_terr  = 1'b0;
    int          m_ptr   = 0;
    int          m_owner = 0;
    int          m_len   = 0;
    bit          m_ten   = 0;
    bit          m_rel   = 0;
    int          w;
    do_reset();
    req = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 3) == 0);
      bus.bus_req   = req;
      bus.xfer_done = done;
      tick();
      if (m_ten) begin
        m_len++;
        if (done || m_len == T) begin
          e_grant = '0;
          e_ack   = 4'(1 << m_owner);
          e_terr  = !done;
          m_ptr   = (m_owner + 1) % N;
          m_ten   = 0;
          m_rel   = 1;
        end
      end else if (m_rel) begin
        e_ack  = '0;
        e_terr = 1'b0;
        e_busy = 1'b0;
        m_rel  = 0;
      end else if (req != 0) begin
        w = 0;
        for (int k = 0; k < N; k++) begin
          if (((req >> ((m_ptr + k) % N)) & 4'd1) != 0) begin
            w = (m_ptr + k) % N;
            break;
          end
        end
        e_grant = 4'(1 << w);
        m_owner = w;
        e_busy  = 1'b1;
        m_ten   = 1;
        m_len   = 0;
      end
      e = {e_grant, e_ack, 2'(m_owner), e_busy, e_terr};
      o = outs();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL random[%0d] req=%b done=%b got %b want %b", cyc, req, done, o, e);
      end
    end
    bus.bus_req   = '0;
    bus.xfer_done = 1'b0;
  endtask

  initial begin
    bus.bus_req   = '0;
    bus.xfer_done = 1'b0;
    test_reset();
    test_done_idle();
    test_single();
    test_contention();
    test_rr_wrap();
    test_timeout();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin bus arbiter that serves N `busmaster` requesters on a shared bus. It samples their `bus_req` lines and issues a one-hot `bus_grant` that is held for one bus tenure. Each tenure ends on a slave completion (`xfer_done`) or on a tenure timeout, and the arbiter then returns a one-cycle `bus_ack` to the owning master. It sits between the master array and the bus slave and closes the IDLE→REQUESTING→GRANTED→IDLE loop that each master runs.

## Interface
- `N`, 4: number of masters; legal range is N ≥ 1.
- `TIMEOUT`, 16: maximum tenure length in cycles; legal range is TIMEOUT ≥ 1.
- `clk`, in, 1: clock; all state changes on the rising edge.
- `reset`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `bus_req`, in, N: request from master i on bit i; level signal, registered at the master.
- `xfer_done`, in, 1: slave completion for the current tenure; sampled only in GRANT.
- `bus_grant`, out, N: one-hot grant, or all-zero; registered.
- `bus_ack`, out, N: one-hot, one-cycle end-of-tenure pulse to the owner; registered.
- `owner`, out, max(1,$clog2(N)): index of the current or last owner; registered.
- `bus_busy`, out, 1: high from the grant cycle through the ack cycle; registered.
- `timeout_err`, out, 1: one-cycle pulse, coincident with `bus_ack`, when a tenure ended by timeout.

## Operation
- Reset (`reset`=0, asynchronous) drives the following values:
  - outputs: `bus_grant`=0, `bus_ack`=0, `owner`=0, `bus_busy`=0, `timeout_err`=0;
  - internal state: state=IDLE, priority pointer `ptr`=0, tenure counter `cnt`=0.
- The state machine is IDLE → GRANT → RELEASE → IDLE.
- IDLE, when `|bus_req`=1:
  - winner = first set bit of `bus_req` scanning ptr, ptr+1, …, N-1, 0, …, ptr-1;
  - `bus_grant`<=onehot(winner), `owner`<=winner, `bus_busy`<=1, `cnt`<=0;
  - next state is GRANT.
- IDLE, when `|bus_req`=0: all outputs hold, state stays IDLE.
- GRANT:
  - `bus_grant` holds and `bus_req` is ignored (the owner drops its request one cycle after seeing the grant);
  - `cnt` increments every cycle;
  - the tenure ends when `xfer_done`=1 or `cnt`==TIMEOUT-1.
- At tenure end:
  - `bus_grant`<=0, `bus_ack`<=onehot(owner);
  - `timeout_err`<=1 only if `xfer_done`=0;
  - `ptr`<=(owner+1) mod N, wrapping from N-1 to 0;
  - next state is RELEASE.
- RELEASE: `bus_ack`<=0, `timeout_err`<=0, `bus_busy`<=0; next state is IDLE.
- Invariants:
  - at most one bit of `bus_grant` is set;
  - `bus_grant` and `bus_ack` are never both nonzero;
  - `bus_ack` is high for exactly one cycle per grant.
- N=1: `ptr` stays 0 and `owner` stays 0.

## Timing
- Request to grant from IDLE: `bus_req[i]` seen high at edge k gives `bus_grant[i]`=1 after edge k.
- Tenure length:
  - `xfer_done` sampled high at edge k gives `bus_ack` pulse after edge k and `bus_grant`=0 after the same edge;
  - with no `xfer_done`, the ack appears after the TIMEOUT-th GRANT edge, counting from the first edge after the grant.
- Turnaround: ack cycle, then one RELEASE cycle, then IDLE. The earliest next grant is 2 cycles after the ack cycle.
- Boundary conditions:
  - `xfer_done` and timeout in the same cycle: counts as done, `timeout_err`=0.
  - `xfer_done` in IDLE or RELEASE: ignored.
  - TIMEOUT=1: the tenure always ends after one GRANT cycle.
  - New requests arriving during GRANT or RELEASE are held by the masters and arbitrated in IDLE.
  - Reset mid-tenure: all outputs go to 0 immediately (asynchronous), the tenure is abandoned, no ack is issued, and `ptr` returns to 0.

## Test plan
- Single requester, N=4, TIMEOUT=16:
  - `bus_req`=0010 → `bus_grant`=0010 after one edge, `owner`=1;
  - `xfer_done` pulsed 3 cycles later → `bus_ack`=0010 for one cycle, `bus_busy` falls in the next cycle, `timeout_err`=0.
- Contention from reset (`ptr`=0): `bus_req`=0101 → grant 0001; after the ack, the request still pending → grant 0100.
- Round-robin wrap:
  - each master requests continuously and ends its tenure via `xfer_done`;
  - grant order must be 0001, 0010, 0100, 1000, 0001;
  - `ptr` wraps from 3 to 0.
- Timeout with TIMEOUT=4, no `xfer_done`: grant lasts exactly 4 cycles, then `bus_ack` and `timeout_err` pulse together for 1 cycle.
- Coincident done and timeout (TIMEOUT=4): `xfer_done`=1 on the 4th GRANT cycle → ack with `timeout_err`=0.
- Reset mid-GRANT:
  - `reset`=0 while `bus_grant`=1000 → all outputs 0 without waiting for a clock edge;
  - after release of reset, `bus_req`=1001 → grant 0001, since `ptr` is back to 0.
